tv_player_checker: RTL and testbench

//  Synthesizable test-vector sequencer/checker that sits directly upstream of a small combinational
//  DUT (e.g. 3-input/1-output logic). Holds a loadable vector table of {inputs, expected output}.

---
 rtl/tv_player_checker_if.sv | 35 +++
 rtl/tv_player_checker.sv | 111 +++++++++++
 tb/tb_tv_player_checker.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tv_player_checker_if.sv
// Bus between the vector player/checker and whoever loads the table, starts runs and closes the DUT loop.
// Handshake: load_en and start are single-cycle requests sampled on the rising clock edge and honoured only while
// the checker is idle or done (state_dbg IDLE/DONE); there is no ready back-pressure, so a request made while busy
// is dropped. When both arrive in the same cycle, the table write takes effect before the run reads the table.
// dut_in -> dut_out is a purely combinational round trip that must settle within one clock cycle.
interface tv_player_checker_if #(
    parameter int IN_W   = 3,
    parameter int OUT_W  = 1,
    parameter int ADDR_W = 4,
    parameter int ERR_W  = 8
);
    logic                  load_en;
    logic [ADDR_W-1:0]     load_addr;
    logic [IN_W+OUT_W-1:0] load_data;
    logic [ADDR_W:0]       num_vec;
    logic                  start;
    logic [IN_W-1:0]       dut_in;
    logic [OUT_W-1:0]      dut_out;
    logic                  busy;
    logic                  done;
    logic                  mismatch;
    logic [ADDR_W:0]       vec_idx;
    logic [ERR_W-1:0]      errors;
    logic [1:0]            state_dbg;

    modport master (
        output load_en, load_addr, load_data, num_vec, start, dut_out,
        input  dut_in, busy, done, mismatch, vec_idx, errors, state_dbg
    );

    modport slave (
        input  load_en, load_addr, load_data, num_vec, start, dut_out,
        output dut_in, busy, done, mismatch, vec_idx, errors, state_dbg
    );
endinterface

// File: rtl/tv_player_checker.sv
// Test-vector sequencer/checker: replays a loadable {inputs, expected} table into a combinational DUT,
// spending one APPLY and one CHECK cycle per vector, and counts mismatches in a saturating counter.
module tv_player_checker #(
    parameter int IN_W   = 3,
    parameter int OUT_W  = 1,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int ERR_W  = 8
) (
    input logic               clk,
    input logic               reset,
    tv_player_checker_if.slave bus
);
    localparam int VEC_W = IN_W + OUT_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   vec_idx_q, vec_idx_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ERR_W-1:0]  errors_q, errors_d;
    logic [IN_W-1:0]   dut_in_q, dut_in_d;
    logic [OUT_W-1:0]  exp_q, exp_d;

    logic [VEC_W-1:0]  table_q [DEPTH];
    logic [VEC_W-1:0]  rd_word;
    logic [ADDR_W:0]   num_clamped;
    logic [ADDR_W:0]   vec_inc;
    logic              ctl_open;
    logic              wr_en;
    logic              miss;

    assign ctl_open    = (state_q == IDLE) || (state_q == DONE);
    assign wr_en       = bus.load_en && ctl_open && ({1'b0, bus.load_addr} < DEPTH_C);
    assign num_clamped = (bus.num_vec > DEPTH_C) ? DEPTH_C : bus.num_vec;
    assign rd_word     = table_q[vec_idx_q[ADDR_W-1:0]];
    assign vec_inc     = vec_idx_q + (ADDR_W + 1)'(1);
    // 4-state inequality so an X/Z response is scored as a failure instead of slipping through.
    assign miss        = (state_q == CHECK) && (bus.dut_out !== exp_q);

    // Table storage survives reset so a reloaded bench does not have to refill it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            table_q[bus.load_addr] <= bus.load_data;
        end
    end

    always_comb begin
        state_d   = state_q;
        vec_idx_d = vec_idx_q;
        count_d   = count_q;
        errors_d  = errors_q;
        dut_in_d  = dut_in_q;
        exp_d     = exp_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    vec_idx_d = '0;
                    errors_d  = '0;
                    count_d   = num_clamped;
                    state_d   = (num_clamped == '0) ? DONE : APPLY;
                end
            end
            APPLY: begin
                dut_in_d = rd_word[VEC_W-1:OUT_W];
                exp_d    = rd_word[OUT_W-1:0];
                state_d  = CHECK;
            end
            CHECK: begin
                vec_idx_d = vec_inc;
                if (miss && (errors_q != '1)) begin
                    errors_d = errors_q + ERR_W'(1);
                end
                state_d = (vec_inc == count_q) ? DONE : APPLY;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            vec_idx_q <= '0;
            count_q   <= '0;
            errors_q  <= '0;
            dut_in_q  <= '0;
            exp_q     <= '0;
        end else begin
            state_q   <= state_d;
            vec_idx_q <= vec_idx_d;
            count_q   <= count_d;
            errors_q  <= errors_d;
            dut_in_q  <= dut_in_d;
            exp_q     <= exp_d;
        end
    end

    assign bus.dut_in    = dut_in_q;
    assign bus.busy      = (state_q == APPLY) || (state_q == CHECK);
    assign bus.done      = (state_q == DONE);
    assign bus.mismatch  = miss;
    assign bus.vec_idx   = vec_idx_q;
    assign bus.errors    = errors_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_tv_player_checker.sv
// Bench for tv_player_checker: drives directed runs against y = a&b | c and scores every CHECK cycle and run end.
module tb_tv_player_checker;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    bit   sb_en;
    int   sat_mm;

    logic [3:0]  good_tab [8];
    logic [3:0]  tab_m [16];
    logic [3:0]  exp_chk_q [$];
    logic [20:0] exp_done_q [$];

    tv_player_checker_if #(.IN_W(3), .OUT_W(1), .ADDR_W(4), .ERR_W(8)) m_if ();
    tv_player_checker_if #(.IN_W(3), .OUT_W(1), .ADDR_W(4), .ERR_W(2)) s_if ();

    tv_player_checker #(.IN_W(3), .OUT_W(1), .DEPTH(16), .ADDR_W(4), .ERR_W(8)) u_dut (
        .clk(clk), .reset(reset), .bus(m_if)
    );
    tv_player_checker #(.IN_W(3), .OUT_W(1), .DEPTH(16), .ADDR_W(4), .ERR_W(2)) u_sat (
        .clk(clk), .reset(reset), .bus(s_if)
    );

    // Combinational DUTs under test: y = a&b | c with dut_in = {a, b, c}.
    assign m_if.dut_out = (m_if.dut_in[2] & m_if.dut_in[1]) | m_if.dut_in[0];
    assign s_if.dut_out = (s_if.dut_in[2] & s_if.dut_in[1]) | s_if.dut_in[0];

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_run(input int n, input logic [15:0] mask, input logic [7:0] err);
        logic [4:0] n5;
        logic [7:0] cyc;
        n5  = 5'(n);
        cyc = 8'(2 * n);
        for (int i = 0; i < n; i++) begin
            exp_chk_q.push_back({tab_m[i][3:1], mask[i]});
        end
        exp_done_q.push_back({n5, err, cyc});
    endtask

    // ---------------- driver tasks ----------------
    task automatic load(input logic [3:0] addr, input logic [3:0] data);
        @(posedge clk); #1;
        m_if.load_en   = 1'b1;
        m_if.load_addr = addr;
        m_if.load_data = data;
        tab_m[addr]    = data;
        @(posedge clk); #1;
        m_if.load_en = 1'b0;
    endtask

    // Start pulse, optionally with a same-cycle table write; returns 1 time unit after the start edge.
    task automatic kick(input logic [4:0] num, input bit with_load, input logic [3:0] addr, input logic [3:0] data);
        @(posedge clk); #1;
        m_if.start   = 1'b1;
        m_if.num_vec = num;
        if (with_load) begin
            m_if.load_en   = 1'b1;
            m_if.load_addr = addr;
            m_if.load_data = data;
            tab_m[addr]    = data;
        end
        @(posedge clk); #1;
        m_if.start   = 1'b0;
        m_if.load_en = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int i;
        for (i = 0; i < 300; i++) begin
            @(negedge clk);
            if (m_if.done) break;
        end
        check({name, "_timeout"}, 32'(i < 300), 32'd1);
        @(posedge clk); #1;
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        int         negc;
        int         start_neg;
        logic       done_prev;
        logic [3:0] e;
        logic [20:0] d;
        negc      = 0;
        start_neg = 0;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            negc++;
            if (sb_en && !reset) begin
                if (m_if.start && (m_if.state_dbg == S_IDLE || m_if.state_dbg == S_DONE)) begin
                    start_neg = negc;
                end
                if (m_if.state_dbg == S_CHECK) begin
                    if (exp_chk_q.size() == 0) begin
                        check("chk_unexpected", 32'(exp_chk_q.size()), 32'd1);
                    end else begin
                        e = exp_chk_q.pop_front();
                        check("dut_in", 32'(m_if.dut_in), 32'(e[3:1]));
                        check("mismatch", 32'(m_if.mismatch), 32'(e[0]));
                    end
                end else begin
                    check("mismatch_idle", 32'(m_if.mismatch), 32'd0);
                end
                if (m_if.done && !done_prev) begin
                    if (exp_done_q.size() == 0) begin
                        check("done_unexpected", 32'(exp_done_q.size()), 32'd1);
                    end else begin
                        d = exp_done_q.pop_front();
                        check("vec_idx", 32'(m_if.vec_idx), 32'(d[20:16]));
                        check("errors", 32'(m_if.errors), 32'(d[15:8]));
                        check("done_latency", 32'(negc - start_neg - 1), 32'(d[7:0]));
                    end
                end
            end
            done_prev = m_if.done;
        end
    end

    initial begin : sat_monitor
        sat_mm = 0;
        forever begin
            @(negedge clk);
            if (s_if.mismatch === 1'b1) sat_mm++;
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int k;
        total = 0;
        bad   = 0;
        sb_en = 1'b0;
        good_tab = '{4'b0000, 4'b0011, 4'b0100, 4'b0111, 4'b1000, 4'b1011, 4'b1101, 4'b1111};
        m_if.load_en = 1'b0; m_if.load_addr = '0; m_if.load_data = '0; m_if.num_vec = '0; m_if.start = 1'b0;
        s_if.load_en = 1'b0; s_if.load_addr = '0; s_if.load_data = '0; s_if.num_vec = '0; s_if.start = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        check("rst_dut_in", 32'(m_if.dut_in), 32'd0);
        check("rst_busy", 32'(m_if.busy), 32'd0);
        check("rst_done", 32'(m_if.done), 32'd0);
        check("rst_mismatch", 32'(m_if.mismatch), 32'd0);
        check("rst_vec_idx", 32'(m_if.vec_idx), 32'd0);
        check("rst_errors", 32'(m_if.errors), 32'd0);
        check("rst_state", 32'(m_if.state_dbg), 32'(S_IDLE));

        // Reset in the middle of an 8-vector run.
        for (int i = 0; i < 8; i++) load(4'(i), good_tab[i]);
        kick(5'd8, 1'b0, 4'd0, 4'd0);
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (m_if.vec_idx == 5'd3) break;
        end
        check("mid_run_reach", 32'(k < 50), 32'd1);
        reset = 1'b1;
        #1;
        check("async_busy", 32'(m_if.busy), 32'd0);
        check("async_vec_idx", 32'(m_if.vec_idx), 32'd0);
        check("async_dut_in", 32'(m_if.dut_in), 32'd0);
        check("async_errors", 32'(m_if.errors), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        check("post_rst_state", 32'(m_if.state_dbg), 32'(S_IDLE));
        repeat (4) @(posedge clk);
        #1 check("post_rst_no_done", 32'(m_if.done), 32'd0);
        sb_en = 1'b1;

        // Empty run from IDLE.
        expect_run(0, 16'h0000, 8'd0);
        kick(5'd0, 1'b0, 4'd0, 4'd0);
        check("empty_busy", 32'(m_if.busy), 32'd0);
        check("empty_done", 32'(m_if.done), 32'd1);
        @(posedge clk); #1;

        // Pass run; entry 7 is first poisoned, then fixed by a write in the start cycle.
        load(4'd7, 4'b1110);
        expect_run(8, 16'h0000, 8'd0);
        tab_m[7] = 4'b1111;
        kick(5'd8, 1'b1, 4'd7, 4'b1111);
        wait_done("pass");
        check("dut_in_hold", 32'(m_if.dut_in), 32'd7);

        // Fail run with entries 2 and 5 inverted.
        load(4'd2, 4'b0101);
        load(4'd5, 4'b1010);
        expect_run(8, 16'h0024, 8'd2);
        kick(5'd8, 1'b0, 4'd0, 4'd0);
        wait_done("fail");

        // Restart from DONE with guards exercised mid-run.
        load(4'd2, good_tab[2]);
        load(4'd5, good_tab[5]);
        expect_run(8, 16'h0000, 8'd0);
        kick(5'd8, 1'b0, 4'd0, 4'd0);
        check("restart_errors_clr", 32'(m_if.errors), 32'd0);
        check("restart_done_low", 32'(m_if.done), 32'd0);
        check("restart_busy", 32'(m_if.busy), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        m_if.load_en = 1'b1; m_if.load_addr = 4'd7; m_if.load_data = 4'b1110;
        @(posedge clk); #1 m_if.load_en = 1'b0;
        m_if.start = 1'b1; m_if.num_vec = 5'd2;
        @(posedge clk); #1 m_if.start = 1'b0;
        wait_done("guard");

        // Oversized count is clamped to the 16-entry table.
        for (int i = 8; i < 16; i++) load(4'(i), good_tab[i - 8]);
        expect_run(16, 16'h0000, 8'd0);
        kick(5'd31, 1'b0, 4'd0, 4'd0);
        wait_done("clamp");

        // Saturation on the 2-bit error counter instance.
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            s_if.load_en = 1'b1; s_if.load_addr = 4'(i); s_if.load_data = good_tab[i] ^ 4'b0001;
        end
        @(posedge clk); #1;
        s_if.load_en = 1'b0;
        s_if.start = 1'b1; s_if.num_vec = 5'd8;
        @(posedge clk); #1 s_if.start = 1'b0;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (s_if.done) break;
        end
        check("sat_timeout", 32'(k < 100), 32'd1);
        check("sat_errors", 32'(s_if.errors), 32'd3);
        check("sat_mm_pulses", 32'(sat_mm), 32'd8);
        check("sat_vec_idx", 32'(s_if.vec_idx), 32'd8);

        repeat (3) @(posedge clk);
        check("chk_q_empty", 32'(exp_chk_q.size()), 32'd0);
        check("done_q_empty", 32'(exp_done_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
